param_serial_fir: RTL and testbench

PARAM_SERIAL_FIR -- requirements
Module: param_serial_fir

---
 rtl/param_serial_fir.sv | 180 ++++++++++++++++++
 tb/tb_param_serial_fir.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_serial_fir.sv
`default_nettype none
// ============================================================================
// Module   : param_serial_fir
// Purpose  : Time-multiplexed direct-form FIR filter. One shared multiplier
//            performs one multiply-accumulate per clock over an NTAPS-deep
//            circular sample buffer. Coefficients are written through a
//            simple address/data strobe while the filter is idle.
// Options  : SERIAL_FIR_SAT_EN - when defined, y saturates the accumulator
//            to the signed OUT_W range; otherwise y is the low OUT_W bits.
// Revision : 1.0 - initial release
// ============================================================================
module param_serial_fir #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NTAPS  = 25,
    parameter int OUT_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [DATA_W-1:0]   x,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_W-1:0]    y,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data
);

    localparam int AW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    // Worst-case sum of NTAPS full-scale products fits in PROD_W + AW bits.
    localparam int ACC_W  = PROD_W + AW;
    localparam logic [AW-1:0] c_LAST = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] sbuf_q [NTAPS];
    logic signed [COEF_W-1:0] coef_q [NTAPS];
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [AW-1:0]            rptr_q, rptr_d;
    logic [AW-1:0]            tap_q,  tap_d;
    logic signed [ACC_W-1:0]  acc_q,  acc_d;

    logic                     w_sample_we;
    logic                     w_coef_we;
    logic                     w_addr_ok;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [OUT_W-1:0]  w_y;

    // Addresses beyond the last tap are silently discarded.
    assign w_addr_ok = ({1'b0, coef_addr} < (AW + 1)'(NTAPS));

    // Single shared multiplier: tap k coefficient times sample x[n-k].
    assign w_prod = coef_q[tap_q] * sbuf_q[rptr_q];

    // Next-state, datapath control and handshake outputs.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        w_sample_we = 1'b0;
        w_coef_we   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready  = 1'b1;
                w_coef_we = coef_we && w_addr_ok;
                if (in_valid) begin
                    w_sample_we = 1'b1;
                    wptr_d      = (wptr_q == c_LAST) ? '0 : wptr_q + 1'b1;
                    // Newest sample sits at the slot being written now.
                    rptr_d      = wptr_q;
                    tap_d       = '0;
                    acc_d       = '0;
                    state_d     = S_MAC;
                end
            end
            S_MAC: begin
                acc_d  = acc_q + ACC_W'(w_prod);
                tap_d  = tap_q + 1'b1;
                // Walk backwards in time through the circular buffer.
                rptr_d = (rptr_q == '0) ? c_LAST : rptr_q - 1'b1;
                if (tap_q == c_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshakes are forced low while reset is held.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers, sample buffer and coefficient store.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            tap_q  <= '0;
            acc_q  <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                sbuf_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            tap_q  <= tap_d;
            acc_q  <= acc_d;
            if (w_sample_we) begin
                sbuf_q[wptr_q] <= x;
            end
            if (w_coef_we) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    // Output formatting: accumulator reduced to OUT_W bits.
    generate
        if (OUT_W >= ACC_W) begin : g_y_ext
            assign w_y = OUT_W'(acc_q);
        end else begin : g_y_narrow
`ifdef SERIAL_FIR_SAT_EN
            localparam logic signed [ACC_W-1:0] c_SAT_MAX =
                {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] c_SAT_MIN =
                {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

            // Clamp to the signed OUT_W range.
            always_comb begin
                if (acc_q > c_SAT_MAX) begin
                    w_y = c_SAT_MAX[OUT_W-1:0];
                end else if (acc_q < c_SAT_MIN) begin
                    w_y = c_SAT_MIN[OUT_W-1:0];
                end else begin
                    w_y = acc_q[OUT_W-1:0];
                end
            end
`else
            assign w_y = acc_q[OUT_W-1:0];
`endif
        end
    endgenerate

    assign y = rst ? '0 : w_y;

endmodule
`default_nettype wire

// File: tb/tb_param_serial_fir.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_serial_fir
// Purpose  : Scoreboard bench for param_serial_fir. Expected outputs are
//            produced by a shift-register reference model when each input
//            handshake occurs and compared as the DUT delivers results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_serial_fir;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int NTAPS  = 25;
    localparam int OUT_W  = 18;
    localparam int AW     = $clog2(NTAPS);
    localparam int BOUND  = 200;
`ifdef SERIAL_FIR_SAT_EN
    localparam longint c_EXP35 = 131071;
`else
    localparam longint c_EXP35 = -121063;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic signed [DATA_W-1:0]  x = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic signed [OUT_W-1:0]   y;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic                      coef_we = 1'b0;
    logic [AW-1:0]             coef_addr = '0;
    logic signed [COEF_W-1:0]  coef_data = '0;

    always #5 clk = ~clk;

    param_serial_fir #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .OUT_W  (OUT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_q[$];
    longint mh [NTAPS];
    longint mx [NTAPS];
    longint last_y = 0;

    // Count a comparison and report any mismatch.
    task automatic check_val(input string tag, input longint obs, input longint expv);
        n_cmp++;
        if (obs != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic longint fmt_out(input longint s);
`ifdef SERIAL_FIR_SAT_EN
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        logic signed [OUT_W-1:0] t;
        t = s[OUT_W-1:0];
        return longint'(t);
`endif
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NTAPS; i++) begin
            mh[i] = 0;
            mx[i] = 0;
        end
    endfunction

    // Shift a new sample into the history and return the filter output.
    function automatic longint model_push(input longint xv);
        longint s;
        for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = xv;
        s = 0;
        for (int k = 0; k < NTAPS; k++) s += mh[k] * mx[k];
        return fmt_out(s);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_in_ready", longint'(in_ready), 1);
    endtask

    task automatic send(input int xv, input bit with_coef = 1'b0,
                        input int caddr = 0, input int cdata = 0);
        @(posedge clk);
        #1;
        x        = DATA_W'(xv);
        in_valid = 1'b1;
        if (with_coef) begin
            coef_we   = 1'b1;
            coef_addr = AW'(caddr);
            coef_data = COEF_W'(cdata);
        end
        wait_ready();
        if (in_ready) begin
            if (with_coef) mh[caddr] = cdata;
            exp_q.push_back(model_push(xv));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    // Write a coefficient; when idle_wr is set it is issued in IDLE.
    task automatic coef_write(input int a, input int d, input bit idle_wr);
        @(posedge clk);
        #1;
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = COEF_W'(d);
        if (idle_wr) begin
            wait_ready();
            if (a < NTAPS) mh[a] = d;
        end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        @(negedge clk);
        check_val("rst_y", longint'(y), 0);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_in_ready", longint'(in_ready), 0);
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_in_ready", longint'(in_ready), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_left", longint'(exp_q.size()), 0);
    endtask

    task automatic impulse();
        send(1);
        repeat (NTAPS) send(0);
        drain();
    endtask

    // Output monitor: latency, spurious outputs and scoreboard compare.
    bit     prev_ov = 1'b0;
    bit     hs_pend = 1'b0;
    int     hs_neg  = 0;
    int     neg_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            hs_pend = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                hs_neg  = neg_cnt;
                hs_pend = 1'b1;
            end
            if (out_valid && !prev_ov) begin
                check_val("out_expected", longint'(exp_q.size() != 0), 1);
                if (hs_pend) check_val("latency", longint'(neg_cnt - hs_neg), NTAPS + 1);
                hs_pend = 1'b0;
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check_val("y", longint'(y), exp_q.pop_front());
                last_y = longint'(y);
            end
        end
        prev_ov = out_valid;
        neg_cnt++;
    end

    initial begin
        int n;
        model_clear();
        do_reset();

        // All coefficients zero after reset: every output is zero.
        repeat (30) send(100);
        drain();

        // h[k] = k+1, plus an out-of-range write, then an impulse.
        do_reset();
        for (int k = 0; k < NTAPS; k++) coef_write(k, k + 1, 1'b1);
        coef_write(NTAPS, 99, 1'b1);
        send(1);
        repeat (NTAPS + 1) send(0);
        drain();

        // Coefficient write during MAC is dropped.
        send(5);
        coef_write(0, -50, 1'b0);
        drain();
        impulse();

        // Coefficient write and handshake in the same cycle.
        send(3, 1'b1, 0, 10);
        drain();

        // Back-pressure in DONE: hold, and ignore in_valid pulses.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(7);
        n = 0;
        while (!out_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_out_valid", longint'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            x        = DATA_W'(77);
            @(negedge clk);
            check_val("hold_pending", longint'(exp_q.size()), 1);
            if (exp_q.size() != 0) check_val("hold_y", longint'(y), exp_q[0]);
            check_val("hold_out_valid", longint'(out_valid), 1);
            check_val("hold_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        impulse();

        // Full-scale accumulation.
        do_reset();
        for (int k = 0; k < NTAPS; k++) coef_write(k, 127, 1'b1);
        repeat (30) send(127);
        drain();
        check_val("fullscale_last_y", last_y, c_EXP35);

        // Reset mid-MAC aborts; then impulse with all-zero coefficients.
        do_reset();
        for (int k = 0; k < NTAPS; k++) coef_write(k, k + 1, 1'b1);
        send(9);
        repeat (4) @(posedge clk);
        do_reset();
        repeat (NTAPS + 5) @(negedge clk);
        impulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
